ppu_rowram_writer: RTL
======================

Name: ppu_rowram_writer

Overview:
- Write side of the double-buffered PPU row RAM that feeds the HDMI video output.
- Holds two 320-entry row buffers: a front buffer read by the video output and a back buffer filled by the PPU renderer.
- Issues per-row render requests to the renderer and accepts its pixel stream through a valid/ready handshake.
- Swaps the front and back buffers on rowram_swap and flags underruns.

Parameters:
- ROW_PIXELS, 320, pixels per row buffer.
- PIX_W, 10, palette-index width per pixel.
- ADDR_W, 9, row-buffer address width.
- NUM_ROWS, 240, rows per frame.

Ports:
- video_clk  in  1  pixel clock.
- rst_n  in  1  reset.
- rowram_rdaddr  in  ADDR_W  read address from the video output.
- rowram_rddata  out  PIX_W  front-buffer data, 1-cycle latency.
- rowram_swap  in  1  single-cycle pulse: exchange front and back.
- vblank_end_soon  in  1  single-cycle pulse: start of frame preparation.
- req_valid  out  1  render request pending.
- req_ready  in  1  renderer accepts the request.
- req_row  out  8  row to render, 0..239.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  writer accepts the pixel.
- pix_data  in  PIX_W  palette index.
- pix_last  in  1  marks the final pixel of a row.
- underrun  out  1  sticky: a swap or frame restart hit an incomplete fill.
- len_err  out  1  sticky: pix_last arrived at an address other than 319, or pixels arrived past 319.
- err_clr  in  1  clears underrun and len_err.

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is video_clk.
- Reset values:
  - rowram_rddata=0, front_sel=0, req_valid=0, req_row=0.
  - pix_ready=0, underrun=0, len_err=0.
  - wr_addr=0, row_cnt=0, state=IDLE.
  - Buffer contents are not cleared.
- Read path:
  - rowram_rddata is registered from buf[front_sel][rowram_rdaddr].
  - Addresses >=ROW_PIXELS return 0.
- States:
  - IDLE: pix_ready=0.
  - REQ: req_valid=1 and req_row held; on req_valid&req_ready go to FILL with wr_addr=0.
  - FILL: pix_ready=1; each pix_valid&pix_ready writes buf[~front_sel][wr_addr] and increments wr_addr.
    - pix_last accepted: go to DONE. If wr_addr!=319 at that beat, set len_err.
    - Beats with wr_addr>=320 are not written and set len_err.
  - DONE: back buffer complete; pix_ready=0; wait for a swap.
  - DRAIN: pix_ready=1; beats are discarded until pix_last is accepted, then go to REQ if a request is pending, else IDLE.
- vblank_end_soon (any state):
  - row_cnt=0, req_row=0.
  - If the state was REQ, FILL or DRAIN, set underrun. Go to DRAIN if the state was FILL, else REQ, with a request for row 0 pending.
- rowram_swap:
  - Toggle front_sel on the same edge.
  - If the state was REQ or FILL, set underrun. A FILL row is abandoned: go to DRAIN.
  - If row_cnt<NUM_ROWS-1: row_cnt+=1, req_row=row_cnt+1, and a request is pending (go to REQ unless draining).
  - Else (row 239 already requested): go to IDLE with no request.
  - When not draining, DONE and IDLE go to REQ or IDLE by the same rule.
- Same-edge write and swap: a pixel write on the swap edge lands in the pre-swap back buffer, which becomes front.
  - If that beat carries pix_last, the row counts as complete and no underrun is raised.
- Simultaneous vblank_end_soon and rowram_swap: vblank_end_soon wins for row_cnt and the request; front_sel still toggles.
- err_clr clears both sticky flags. An error event in the same cycle wins (flag stays 1).
- req_valid is only deasserted by the handshake, an abandon, or reset. req_row is stable while req_valid=1.
- A reset mid-fill returns to IDLE. Nothing is requested until the next vblank_end_soon.

Decomposition:
- Package ppu_rowram_pkg holds:
  - ROW_PIXELS, NUM_ROWS, PIX_W, ADDR_W.
  - The writer state enum {IDLE, REQ, FILL, DONE, DRAIN}.
- One sub-module, ppu_rowram_bank: a simple dual-port 320x10 RAM with a 1-cycle registered read. Instantiate it twice. front_sel muxes the read data and steers the write enable.

Test Plan:
1. vblank_end_soon pulse, renderer accepts after 3 cycles, streams 320 beats with value=address, pix_last on beat 319 -> req_row=0, state DONE, no error flags. After a swap, rowram_rdaddr=5 gives rowram_rddata=5 one cycle later.
2. Full frame: vblank_end_soon, then 240 swaps, each preceded by a complete fill -> req_row sequence is 0..239. No request follows the 240th swap. underrun=0.
3. Swap after only 100 beats of row 7 -> underrun=1, front_sel toggles, writer enters DRAIN. The 220 remaining beats are accepted and discarded. req_row=8 is issued after pix_last.
4. pix_last on beat 200 -> len_err=1. Separately, 330 beats -> beats 320..329 are not written and len_err=1. err_clr pulse clears the flag.
5. pix_last accepted on the same edge as rowram_swap -> underrun stays 0. The new front buffer reads back all 320 values correctly.
6. Assert rst_n low mid-FILL -> outputs take their reset values immediately (asynchronously). After release, req_valid stays 0 until vblank_end_soon.

Source files
------------

// File: rtl/ppu_rowram_pkg.sv
// Shared definitions for the PPU row-RAM writer slice.
// Holds the row geometry, the pixel and address widths, the writer state
// encoding, and a saturating address-increment helper.
package ppu_rowram_pkg;

    localparam int ROW_PIXELS = 320;
    localparam int PIX_W      = 10;
    localparam int ADDR_W     = 9;
    localparam int NUM_ROWS   = 240;

    // Typed copies of the geometry for direct comparison against registers.
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROW_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(ROW_PIXELS);
    localparam logic [7:0]        ROW_LAST  = 8'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FILL  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } wr_state_e;

    // Saturating increment.
    // An overlong row keeps counting past the buffer end, so the writer can
    // still tell that beats are out of range, but the count never wraps back
    // into the valid address window.
    function automatic logic [ADDR_W-1:0] addr_inc_sat(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        if (a == {ADDR_W{1'b1}}) begin
            r = a;
        end else begin
            r = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/ppu_rowram_writer_if.sv
// Render-request and pixel-stream handshake between the row-RAM writer and
// the PPU renderer.
//   req_valid/req_ready/req_row        : per-row render request (writer -> renderer)
//   pix_valid/pix_ready/pix_data/last  : pixel stream (renderer -> writer)
// Modports:
//   master : the writer side.
//   slave  : the renderer side.
interface ppu_rowram_writer_if;
    import ppu_rowram_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_row;
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_last;

    modport master (
        output req_valid, req_row, pix_ready,
        input  req_ready, pix_valid, pix_data, pix_last
    );

    modport slave (
        input  req_valid, req_row, pix_ready,
        output req_ready, pix_valid, pix_data, pix_last
    );

endinterface

// File: rtl/ppu_rowram_bank.sv
// One 320 x PIX_W row buffer.
// Simple dual-port RAM: one write port and one read port, with a registered
// read of 1-cycle latency.
//   clk, rst_n          : clock and async active-low reset (read register only)
//   we, waddr, wdata    : write port
//   raddr, rdata        : read port; out-of-range addresses read as 0
module ppu_rowram_bank
    import ppu_rowram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [ROW_PIXELS];

    // Storage write port.
    // Contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we && (waddr < ADDR_END)) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= {PIX_W{1'b0}};
        end else if (raddr < ADDR_END) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= {PIX_W{1'b0}};
        end
    end

endmodule

// File: rtl/ppu_rowram_writer.sv
// Write side of the double-buffered PPU row RAM feeding the HDMI output.
// Requests one row at a time from the renderer and fills the back buffer
// from its pixel stream. Exchanges front and back on rowram_swap.
//   video_clk, rst_n         : pixel clock, async active-low reset
//   rowram_rdaddr/rddata     : front-buffer read port, 1-cycle latency
//   rowram_swap              : exchange front and back buffers (pulse)
//   vblank_end_soon          : restart the frame at row 0 (pulse)
//   rnd                      : request/pixel handshake with the renderer
//   underrun, len_err        : sticky error flags; err_clr clears both
module ppu_rowram_writer
    import ppu_rowram_pkg::*;
(
    input  logic                 video_clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    rowram_rdaddr,
    output logic [PIX_W-1:0]     rowram_rddata,
    input  logic                 rowram_swap,
    input  logic                 vblank_end_soon,
    ppu_rowram_writer_if.master  rnd,
    output logic                 underrun,
    output logic                 len_err,
    input  logic                 err_clr
);

    wr_state_e         state_r, state_n;
    logic              front_sel_r, rd_sel_r;
    logic              req_valid_r, req_valid_n;
    logic [7:0]        req_row_r, req_row_n;
    logic              req_pend_r, req_pend_n;
    logic [7:0]        row_cnt_r, row_cnt_n;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_n;
    logic              pix_ready_r, underrun_r, len_err_r;
    logic [PIX_W-1:0]  rdata0_s, rdata1_s;

    logic beat_s, hs_s, in_fill_s, fill_done_s, drain_done_s, open_fill_s;
    logic drain_open_s, more_rows_s, wr_en_s, len_evt_s, ur_swap_s, ur_vbl_s;

    assign beat_s       = rnd.pix_valid & pix_ready_r;
    assign hs_s         = req_valid_r & rnd.req_ready;
    assign in_fill_s    = (state_r == FILL);
    assign fill_done_s  = in_fill_s & beat_s & rnd.pix_last;
    assign drain_done_s = (state_r == DRAIN) & beat_s & rnd.pix_last;

    // A row is "open" when the renderer owes us pixels for it.
    // This covers a request accepted on this very edge.
    assign open_fill_s  = (in_fill_s & ~fill_done_s) | ((state_r == REQ) & hs_s);
    assign drain_open_s = ((state_r == DRAIN) & ~drain_done_s) | open_fill_s;
    assign more_rows_s  = (row_cnt_r < ROW_LAST);
    assign wr_en_s      = in_fill_s & beat_s & (wr_addr_r < ADDR_END);

    assign len_evt_s = in_fill_s & beat_s &
                       (~(wr_addr_r < ADDR_END) | (rnd.pix_last & (wr_addr_r != ADDR_LAST)));

    // A pix_last accepted on the swap edge completes the row, so it is not
    // an underrun.
    assign ur_swap_s = rowram_swap & ((state_r == REQ) | (in_fill_s & ~fill_done_s));
    assign ur_vbl_s  = vblank_end_soon &
                       ((state_r == REQ) | (state_r == FILL) | (state_r == DRAIN));

    // Writes go to the current back buffer.
    // On a swap edge that is the buffer about to become front.
    ppu_rowram_bank u_bank0 (
        .clk   (video_clk),
        .rst_n (rst_n),
        .we    (wr_en_s & front_sel_r),
        .waddr (wr_addr_r),
        .wdata (rnd.pix_data),
        .raddr (rowram_rdaddr),
        .rdata (rdata0_s)
    );

    ppu_rowram_bank u_bank1 (
        .clk   (video_clk),
        .rst_n (rst_n),
        .we    (wr_en_s & ~front_sel_r),
        .waddr (wr_addr_r),
        .wdata (rnd.pix_data),
        .raddr (rowram_rdaddr),
        .rdata (rdata1_s)
    );

    // rd_sel_r remembers which bank was front when the address was presented.
    assign rowram_rddata = rd_sel_r ? rdata1_s : rdata0_s;
    assign rnd.req_valid = req_valid_r;
    assign rnd.req_row   = req_row_r;
    assign rnd.pix_ready = pix_ready_r;
    assign underrun      = underrun_r;
    assign len_err       = len_err_r;

    // Next-state and next-request computation.
    // Priority: normal progress, then swap, then vblank.
    // When a pending request's row must change, req_valid drops for one cycle
    // (abandon) and REQ re-raises it, so req_row never changes under a valid.
    always_comb begin
        state_n     = state_r;
        req_valid_n = req_valid_r;
        req_row_n   = req_row_r;
        req_pend_n  = req_pend_r;
        row_cnt_n   = row_cnt_r;
        wr_addr_n   = wr_addr_r;
        case (state_r)
            IDLE: state_n = IDLE;
            REQ: begin
                if (hs_s) begin
                    state_n     = FILL;
                    req_valid_n = 1'b0;
                    req_pend_n  = 1'b0;
                    wr_addr_n   = {ADDR_W{1'b0}};
                end else begin
                    req_valid_n = 1'b1;
                end
            end
            FILL: begin
                if (beat_s) begin
                    wr_addr_n = addr_inc_sat(wr_addr_r);
                    state_n   = rnd.pix_last ? DONE : FILL;
                end else begin
                    state_n = FILL;
                end
            end
            DONE: state_n = DONE;
            DRAIN: begin
                if (drain_done_s && req_pend_r) begin
                    state_n     = REQ;
                    req_valid_n = 1'b1;
                    req_pend_n  = 1'b0;
                end else if (drain_done_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n     = IDLE;
                req_valid_n = 1'b0;
                req_pend_n  = 1'b0;
            end
        endcase

        if (rowram_swap) begin
            if (more_rows_s) begin
                row_cnt_n = row_cnt_r + 8'd1;
                req_row_n = row_cnt_r + 8'd1;
            end else begin
                row_cnt_n = row_cnt_r;
            end
            if (drain_open_s) begin
                state_n     = DRAIN;
                req_valid_n = 1'b0;
                req_pend_n  = more_rows_s;
            end else if (more_rows_s) begin
                state_n     = REQ;
                req_valid_n = (state_r != REQ);
                req_pend_n  = 1'b0;
            end else begin
                state_n     = IDLE;
                req_valid_n = 1'b0;
                req_pend_n  = 1'b0;
            end
        end else begin
            req_pend_n = req_pend_n;
        end

        if (vblank_end_soon) begin
            row_cnt_n = 8'd0;
            req_row_n = 8'd0;
            if (open_fill_s) begin
                state_n     = DRAIN;
                req_valid_n = 1'b0;
                req_pend_n  = 1'b1;
            end else begin
                state_n     = REQ;
                req_valid_n = (state_r != REQ);
                req_pend_n  = 1'b0;
            end
        end else begin
            row_cnt_n = row_cnt_n;
        end
    end

    // Writer state and all registered outputs.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            front_sel_r <= 1'b0;
            rd_sel_r    <= 1'b0;
            req_valid_r <= 1'b0;
            req_row_r   <= 8'd0;
            req_pend_r  <= 1'b0;
            row_cnt_r   <= 8'd0;
            wr_addr_r   <= {ADDR_W{1'b0}};
            pix_ready_r <= 1'b0;
            underrun_r  <= 1'b0;
            len_err_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            front_sel_r <= front_sel_r ^ rowram_swap;
            rd_sel_r    <= front_sel_r;
            req_valid_r <= req_valid_n;
            req_row_r   <= req_row_n;
            req_pend_r  <= req_pend_n;
            row_cnt_r   <= row_cnt_n;
            wr_addr_r   <= wr_addr_n;
            pix_ready_r <= (state_n == FILL) | (state_n == DRAIN);
            underrun_r  <= ur_swap_s | ur_vbl_s | (underrun_r & ~err_clr);
            len_err_r   <= len_evt_s | (len_err_r & ~err_clr);
        end
    end

endmodule
